serializer: RTL and testbench
=============================

// Module: serializer
// PURPOSE
//   Parallel-to-serial converter: accepts one WIDTH-bit word plus a bit count,
//   shifts it out MSB first, one bit per clk_i with a per-bit valid strobe.
//   Transmit side of the serial link terminated by the deserializer block:
//   a full-width word (data_mod_i = 0) arrives there as exactly one word.
// PARAMETERS
//   WIDTH  16               parallel word width; power of two, >= 4
//   MOD_W  $clog2(WIDTH)    width of data_mod_i (derived, do not override)
// PORTS
//   clk_i             in   1      system clock; all logic on posedge
//   srst_i            in   1      synchronous reset, active-high
//   data_i            in   WIDTH  parallel word; bit WIDTH-1 sent first
//   data_mod_i        in   MOD_W  bits to send from MSB down; 0 = all WIDTH
//   data_val_i        in   1      word/mod valid; sampled only when busy_o = 0
//   ser_data_o        out  1      serial bit
//   ser_data_val_o    out  1      ser_data_o valid this cycle
//   busy_o            out  1      transfer in progress; new words ignored
// BEHAVIOUR
//   - Reset: srst_i = 1 at an edge -> next cycle ser_data_o = 0,
//     ser_data_val_o = 0, busy_o = 0, state IDLE, shift reg and counter
//     cleared. Applies mid-transfer: remaining bits dropped, no trailing valid.
//   - All outputs registered; no combinational input->output path.
//   - Effective length N: data_mod_i = 0 -> N = WIDTH; 3..WIDTH-1 -> N = mod;
//     1 or 2 -> word rejected (no output, busy_o stays 0).
//   - FSM states IDLE, SHIFT.
//     IDLE: edge with data_val_i = 1, N valid -> latch data_i, load counter
//       N-1, go SHIFT. Otherwise stay IDLE.
//     SHIFT: each cycle drives latched bit [WIDTH-1-k], k = 0..N-1, with
//       ser_data_val_o = 1; counter decrements; when 0 -> IDLE next edge.
//   - Timing: word accepted at edge T -> bit WIDTH-1 on outputs T+1 ..
//     last bit at T+N; busy_o = 1 for cycles T+1..T+N, 0 from T+N+1.
//   - Back-to-back: a word presented in cycle T+N (busy_o = 1) is ignored;
//     earliest accept edge is T+N+1 -> one idle cycle between words.
//   - data_val_i / data_i / data_mod_i changes during SHIFT have no effect.
//   - Outside SHIFT: ser_data_val_o = 0, ser_data_o = 0.
// TESTING
//   1. WIDTH=16, data_i=16'hA5C3, mod=0, val 1 cycle -> 16 valid bits
//      1010_0101_1100_0011 in order, busy_o high exactly 16 cycles.
//   2. data_i=16'hF000, mod=4 -> 4 valid bits 1,1,1,1, then val/busy drop;
//      data_i=16'h8000, mod=3 -> 1,0,0.
//   3. mod=1 and mod=2 with val=1 -> no ser_data_val_o, busy_o stays 0.
//   4. Hold data_val_i=1 continuously with alternating 16'hFFFF / 16'h0000,
//      mod=0 -> words serialized back-to-back with one idle cycle each;
//      words presented while busy_o=1 never appear.
//   5. srst_i pulsed after 7th bit of a 16-bit transfer -> next cycle
//      val=0, busy=0, ser_data_o=0; following word 16'h1234 sent intact.
//   6. Loopback into deserializer, 1000 random full-width words -> every
//      deserialized word equals the sent word, in order.

Source files
------------

// File: rtl/serializer_if.sv
// Parallel word input and serial bit output of the serializer.
// The master side supplies words; the slave side is the serializer.
interface serializer_if #(
    parameter int WIDTH = 16
);
    localparam int MOD_W = $clog2(WIDTH);

    logic [WIDTH-1:0] data_i;
    logic [MOD_W-1:0] data_mod_i;
    logic             data_val_i;
    logic             ser_data_o;
    logic             ser_data_val_o;
    logic             busy_o;

    modport master (
        output data_i,
        output data_mod_i,
        output data_val_i,
        input  ser_data_o,
        input  ser_data_val_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  data_mod_i,
        input  data_val_i,
        output ser_data_o,
        output ser_data_val_o,
        output busy_o
    );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter: shifts a latched word out MSB first, one bit
// per clock, for 3..WIDTH bits (data_mod_i = 0 selects the full width).
module serializer #(
    parameter int WIDTH = 16,
    parameter int MOD_W = $clog2(WIDTH)
) (
    input  logic         clk_i,
    input  logic         srst_i,
    serializer_if.slave  bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [MOD_W-1:0] cnt, cnt_nxt;
    logic             ser_data, ser_data_nxt;
    logic             ser_val, ser_val_nxt;

    // Lengths 1 and 2 are rejected; 0 encodes a full-width word.
    function automatic logic len_ok(input logic [MOD_W-1:0] m);
        return (m == '0) || (m >= MOD_W'(3));
    endfunction

    function automatic logic [MOD_W-1:0] len_m1(input logic [MOD_W-1:0] m);
        return (m == '0) ? {MOD_W{1'b1}} : m - 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            ser_data <= 1'b0;
            ser_val  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            ser_data <= ser_data_nxt;
            ser_val  <= ser_val_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        cnt_nxt      = cnt;
        ser_data_nxt = 1'b0;
        ser_val_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // The MSB goes straight to the output register on accept, so
                // the shift register holds only the bits still to come.
                if (bus.data_val_i && len_ok(bus.data_mod_i)) begin
                    state_nxt    = SHIFT;
                    ser_data_nxt = bus.data_i[WIDTH-1];
                    ser_val_nxt  = 1'b1;
                    shreg_nxt    = {bus.data_i[WIDTH-2:0], 1'b0};
                    cnt_nxt      = len_m1(bus.data_mod_i);
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    ser_data_nxt = shreg[WIDTH-1];
                    ser_val_nxt  = 1'b1;
                    shreg_nxt    = {shreg[WIDTH-2:0], 1'b0};
                    cnt_nxt      = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ser_data_o     = ser_data;
    assign bus.ser_data_val_o = ser_val;
    assign bus.busy_o         = (state == SHIFT);

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for the serializer: a behavioural model queues expected
// bits on every accepted word; the monitor pops and compares them.
module tb_serializer;

    logic clk = 1'b0;
    logic srst;

    always #5 clk = ~clk;

    serializer_if #(.WIDTH(16)) bus ();

    serializer #(.WIDTH(16)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tb_len(input logic [3:0] m);
        if (m == 4'd0) return 16;
        if (m < 4'd3) return 0;
        return int'(m);
    endfunction

    // Reference model: remaining-bit counter plus expected-bit queue
    bit          exp_q[$];
    logic [15:0] word_q[$];
    int          rem = 0;
    bit          loop_en = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge clk) begin
        int n;
        if (srst) begin
            rem = 0;
            exp_q.delete();
        end else if (rem > 0) begin
            rem--;
        end else if (bus.data_val_i === 1'b1) begin
            n = tb_len(bus.data_mod_i);
            if (n > 0) begin
                rem = n;
                for (int k = 0; k < n; k++) exp_q.push_back(bus.data_i[15-k]);
                if (loop_en) word_q.push_back(bus.data_i);
            end
        end
    end

    // Monitor, sampled on the falling edge
    int          vcnt = 0;
    int          bcnt = 0;
    int          rx_words = 0;
    int          asm_n = 0;
    logic [15:0] asm_w = '0;

    always @(negedge clk) begin
        bit          b;
        logic [15:0] w;
        if (mon_en) begin
            chk("busy", bus.busy_o, 32'(rem > 0));
            chk("val", bus.ser_data_val_o, 32'(rem > 0));
            if (bus.busy_o === 1'b1) bcnt++;
            if (bus.ser_data_val_o === 1'b1) begin
                vcnt++;
                chk("q_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    chk("bit", bus.ser_data_o, 32'(b));
                end
                if (loop_en) begin
                    asm_w = {asm_w[14:0], bus.ser_data_o};
                    asm_n++;
                    if (asm_n == 16) begin
                        asm_n = 0;
                        rx_words++;
                        chk("loop_q_nonempty", 32'(word_q.size() > 0), 1);
                        if (word_q.size() > 0) begin
                            w = word_q.pop_front();
                            chk("loop_word", asm_w, w);
                        end
                    end
                end
            end else begin
                chk("idle_data", bus.ser_data_o, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] m);
        bus.data_i     = d;
        bus.data_mod_i = m;
        bus.data_val_i = 1'b1;
        tick(1);
        bus.data_val_i = 1'b0;
    endtask

    initial begin
        srst           = 1'b1;
        bus.data_i     = '0;
        bus.data_mod_i = '0;
        bus.data_val_i = 1'b0;
        tick(2);
        srst = 1'b0;
        @(negedge clk);
        chk("rst_val", bus.ser_data_val_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_data", bus.ser_data_o, 0);
        mon_en = 1'b1;
        tick(1);

        // Full-width word
        vcnt = 0; bcnt = 0;
        send(16'hA5C3, 4'd0);
        tick(20);
        chk("t1_bits", vcnt, 16);
        chk("t1_busy_cycles", bcnt, 16);

        // Short words
        vcnt = 0; bcnt = 0;
        send(16'hF000, 4'd4);
        tick(8);
        chk("t2a_bits", vcnt, 4);
        chk("t2a_busy_cycles", bcnt, 4);
        vcnt = 0;
        send(16'h8000, 4'd3);
        tick(6);
        chk("t2b_bits", vcnt, 3);

        // Rejected lengths
        vcnt = 0; bcnt = 0;
        send(16'hFFFF, 4'd1);
        tick(3);
        send(16'hFFFF, 4'd2);
        tick(5);
        chk("t3_bits", vcnt, 0);
        chk("t3_busy_cycles", bcnt, 0);

        // Valid held high, data toggling every cycle: accepts every 17 edges
        vcnt = 0;
        bus.data_mod_i = 4'd0;
        bus.data_i     = 16'hFFFF;
        bus.data_val_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            bus.data_i = ~bus.data_i;
        end
        bus.data_val_i = 1'b0;
        tick(20);
        chk("t4_bits", vcnt, 64);

        // Reset in the middle of a transfer
        vcnt = 0;
        send(16'hBEEF, 4'd0);
        tick(6);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        @(negedge clk);
        chk("t5_val", bus.ser_data_val_o, 0);
        chk("t5_busy", bus.busy_o, 0);
        chk("t5_data", bus.ser_data_o, 0);
        chk("t5_bits_before_rst", vcnt, 7);
        tick(2);
        vcnt = 0;
        send(16'h1234, 4'd0);
        tick(20);
        chk("t5_after_bits", vcnt, 16);

        // Loopback of random full-width words at the fastest accept rate
        loop_en = 1'b1;
        asm_n   = 0;
        rx_words = 0;
        for (int i = 0; i < 1000; i++) begin
            send(16'($urandom), 4'd0);
            tick(16);
        end
        tick(20);
        chk("t6_words", rx_words, 1000);
        chk("t6_word_q_empty", word_q.size(), 0);
        chk("t6_bit_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
